// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU core and loader/debug port) in front of a single-port RAM.
// Sticky-owner arbitration with a burst limit, an exclusive loader lock and owner-tagged read return.
module mem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    input  logic          ld_lock,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,

    output logic          locked
);

    localparam logic       OWN_CPU   = 1'b0;
    localparam logic       OWN_LD    = 1'b1;
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic              last_owner;
    logic [3:0]        burst_cnt;
    logic              locked_q;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_own;

    logic cpu_win;
    logic ld_win;
    logic any_gnt;
    logic win_owner;
    logic win_we;
    logic rd_issue;
    logic ret_vld;
    logic ret_own;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        cpu_win = 1'b0;
        ld_win  = 1'b0;
        if (!rst_n) begin
            cpu_win = 1'b0;
            ld_win  = 1'b0;
        end else if (locked_q) begin
            ld_win = ld_req;
        end else if (cpu_req && !ld_req) begin
            cpu_win = 1'b1;
        end else if (ld_req && !cpu_req) begin
            ld_win = 1'b1;
        end else if (cpu_req && ld_req) begin
            if (burst_cnt == BURST_MAX) begin
                if (last_owner == OWN_CPU) ld_win = 1'b1;
                else                       cpu_win = 1'b1;
            end else begin
                if (last_owner == OWN_CPU) cpu_win = 1'b1;
                else                       ld_win = 1'b1;
            end
        end
    end

    assign any_gnt   = cpu_win | ld_win;
    assign win_owner = ld_win ? OWN_LD : OWN_CPU;
    assign win_we    = ld_win ? ld_we : cpu_we;
    assign rd_issue  = any_gnt & ~win_we;

    assign cpu_gnt  = cpu_win;
    assign ld_gnt   = ld_win;
    assign ram_rden = rd_issue;
    assign ram_wren = any_gnt & win_we;

    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        if (ld_win) begin
            ram_addr = ld_addr;
            ram_data = ld_wdata;
        end else if (cpu_win) begin
            ram_addr = cpu_addr;
            ram_data = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWN_CPU;
            burst_cnt  <= 4'd0;
        end else if (!any_gnt) begin
            burst_cnt <= 4'd0;
        end else if (win_owner == last_owner) begin
            if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 4'd1;
        end else begin
            burst_cnt  <= 4'd1;
            last_owner <= win_owner;
        end
    end

    // Release takes priority: once locked, the first edge with ld_lock low unlocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
        end else if (locked_q) begin
            if (!ld_lock) locked_q <= 1'b0;
        end else if (ld_win && ld_lock) begin
            locked_q <= 1'b1;
        end
    end

    assign locked = locked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            pipe_own[0] <= win_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    assign ret_vld = pipe_vld[RD_LAT-1];
    assign ret_own = pipe_own[RD_LAT-1];

    assign cpu_rvalid = ret_vld & (ret_own == OWN_CPU);
    assign ld_rvalid  = ret_vld & (ret_own == OWN_LD);
    assign cpu_rdata  = cpu_rvalid ? ram_q : '0;
    assign ld_rdata   = ld_rvalid  ? ram_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural single-port RAM (RD_LAT=1).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       ld_req, ld_we, ld_gnt, ld_rvalid, ld_lock;
    logic [7:0] ld_addr, ld_wdata, ld_rdata;
    logic [7:0] ram_addr, ram_data, ram_q;
    logic       ram_rden, ram_wren, locked;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(8), .DW(8), .RD_LAT(1), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_lock(ld_lock),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_q(ram_q), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read (one cycle), write on the same edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h11] = 8'h5A;
        ram_q = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_rden) ram_q = mem[ram_addr];
            if (ram_wren) mem[ram_addr] = ram_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ld_req = 0; ld_we = 0; ld_addr = 8'h00; ld_wdata = 8'h00; ld_lock = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        cpu_addr = 8'h33; cpu_wdata = 8'h44; ld_addr = 8'h55; ld_wdata = 8'h66;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            cpu_req = i[0]; ld_req = ~i[0]; cpu_we = i[1]; ld_we = ~i[1];
            @(negedge clk);
            checks++;
            if ({cpu_gnt, ld_gnt, ram_rden, ram_wren, cpu_rvalid, ld_rvalid, locked} !== 7'b0) begin
                errors++;
                $display("FAIL reset_ctrl cycle %0d: got %b required 0000000", i,
                         {cpu_gnt, ld_gnt, ram_rden, ram_wren, cpu_rvalid, ld_rvalid, locked});
            end
            checks++;
            if ({ram_addr, ram_data, cpu_rdata, ld_rdata} !== 32'h0) begin
                errors++;
                $display("FAIL reset_data cycle %0d: got %h required 0", i,
                         {ram_addr, ram_data, cpu_rdata, ld_rdata});
            end
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ld_gnt, ram_rden, ram_wren, cpu_rvalid} !== 5'b10100) begin
            errors++;
            $display("FAIL read_grant: got %b required 10100", {cpu_gnt, ld_gnt, ram_rden, ram_wren, cpu_rvalid});
        end
        checks++;
        if (ram_addr !== 8'h10) begin
            errors++;
            $display("FAIL read_addr: got %h required 10", ram_addr);
        end
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, ld_rvalid} !== 2'b10 || cpu_rdata !== 8'hA5 || ld_rdata !== 8'h00) begin
            errors++;
            $display("FAIL read_return: got v=%b cpu=%h ld=%h required v=10 cpu=a5 ld=00",
                     {cpu_rvalid, ld_rvalid}, cpu_rdata, ld_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL read_pulse_width: got v=%b d=%h required v=0 d=00", cpu_rvalid, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        bit exp_ld;
        bit prev_ld;
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        ld_req = 1; ld_we = 0; ld_addr = 8'h11;
        for (int i = 0; i < 12; i++) begin
            exp_ld = ((i / 4) % 2) == 1;
            @(negedge clk);
            checks++;
            if ({cpu_gnt, ld_gnt} !== {~exp_ld, exp_ld}) begin
                errors++;
                $display("FAIL contention_gnt cycle %0d: got %b required %b", i, {cpu_gnt, ld_gnt}, {~exp_ld, exp_ld});
            end
            if (i > 0) begin
                prev_ld = (((i - 1) / 4) % 2) == 1;
                checks++;
                if ({cpu_rvalid, ld_rvalid} !== {~prev_ld, prev_ld} ||
                    (prev_ld ? ld_rdata : cpu_rdata) !== (prev_ld ? 8'h5A : 8'hA5)) begin
                    errors++;
                    $display("FAIL contention_ret cycle %0d: got v=%b cpu=%h ld=%h", i,
                             {cpu_rvalid, ld_rvalid}, cpu_rdata, ld_rdata);
                end
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, ld_rvalid} !== 2'b10 || cpu_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL contention_last_ret: got v=%b cpu=%h required v=10 cpu=a5", {cpu_rvalid, ld_rvalid}, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_single();
        int first_ld;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
                errors++;
                $display("FAIL single_cpu cycle %0d: got cpu_gnt=%b ld_gnt=%b required 1 0", i, cpu_gnt, ld_gnt);
            end
            next_cycle();
        end
        ld_req = 1; ld_we = 0; ld_addr = 8'h11;
        first_ld = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ld_gnt === 1'b1 && first_ld < 0) first_ld = k;
            next_cycle();
        end
        checks++;
        if (first_ld < 0) begin
            errors++;
            $display("FAIL single_ld_wait: loader not granted within 4 cycles, required grant");
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_lock();
        ld_req = 1; ld_we = 1; ld_addr = 8'h00; ld_wdata = 8'h3C; ld_lock = 1;
        @(negedge clk);
        checks++;
        if ({ld_gnt, ram_wren, ram_rden, locked} !== 4'b1100 || ram_data !== 8'h3C || ram_addr !== 8'h00) begin
            errors++;
            $display("FAIL lock_ld_write: got %b data=%h addr=%h required 1100 data=3c addr=00",
                     {ld_gnt, ram_wren, ram_rden, locked}, ram_data, ram_addr);
        end
        next_cycle();
        ld_req = 0; ld_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({locked, cpu_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL lock_hold cycle %0d: got locked,cpu_gnt=%b required 10", i, {locked, cpu_gnt});
            end
            next_cycle();
        end
        ld_lock = 0;
        @(negedge clk);
        checks++;
        if ({locked, cpu_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock_release_cycle: got locked,cpu_gnt=%b required 10", {locked, cpu_gnt});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({locked, cpu_gnt, ram_rden} !== 3'b011) begin
            errors++;
            $display("FAIL lock_after_release: got locked,cpu_gnt,rden=%b required 011", {locked, cpu_gnt, ram_rden});
        end
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL lock_readback: got v=%b d=%h required v=1 d=3c", cpu_rvalid, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_write();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h7E;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ram_wren, ram_rden} !== 3'b110 || ram_addr !== 8'h20 || ram_data !== 8'h7E) begin
            errors++;
            $display("FAIL write_drive: got %b addr=%h data=%h required 110 addr=20 data=7e",
                     {cpu_gnt, ram_wren, ram_rden}, ram_addr, ram_data);
        end
        next_cycle();
        cpu_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_wren, ram_rden, cpu_rvalid, ld_rvalid} !== 4'b0 || ram_addr !== 8'h00 || ram_data !== 8'h00) begin
                errors++;
                $display("FAIL write_after cycle %0d: got %b addr=%h data=%h required 0000 addr=00 data=00", i,
                         {ram_wren, ram_rden, cpu_rvalid, ld_rvalid}, ram_addr, ram_data);
            end
            next_cycle();
        end
        checks++;
        if (mem[8'h20] !== 8'h7E) begin
            errors++;
            $display("FAIL write_mem: got %h required 7e", mem[8'h20]);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant: got %b required 1", cpu_gnt);
        end
        @(posedge clk);
        rst_n = 0;
        cpu_req = 0;
        #1;
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL midrst_async: got v=%b d=%h required v=0 d=00", cpu_rvalid, cpu_rdata);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (cpu_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_rvalid cycle %0d: got %b required 0", i, cpu_rvalid);
            end
        end
        next_cycle();
        cpu_req = 1; cpu_addr = 8'h10;
        ld_req = 1; ld_addr = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_gnt, ld_gnt} !== ((i < 4) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL midrst_contention cycle %0d: got %b required %b", i,
                         {cpu_gnt, ld_gnt}, (i < 4) ? 2'b10 : 2'b01);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_read();
        test_contention();
        test_single();
        test_lock();
        test_write();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
